// File: rtl/riscv_pkg.sv
// Shared encodings for the memory/writeback stage: opcodes, funct3 codes,
// FSM states and the small alignment/byte-lane helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_RESP = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_PC4  = 2'd2,
    WB_LOAD = 2'd3
  } wb_sel_t;

  // size is funct3[1:0]: 0 = byte, 1 = halfword, otherwise word
  function automatic logic access_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~addr_lo[0];
      default: return addr_lo == 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/halfword out of a load word and sign- or
// zero-extends it according to funct3.
module load_extract
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    result = shifted;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_writeback.sv
// Memory/writeback stage: issues data-memory requests, stalls the pipeline
// while memory is busy, and produces the writeback and forwarding values.
module mem_writeback
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALU_out_reg,
  input  logic [XLEN-1:0] PC_addr_Execute,
  input  logic [31:0]     Inst_Execute,
  input  logic [XLEN-1:0] Data_W,
  output logic [XLEN-1:0] DMem_addr,
  output logic [XLEN-1:0] DMem_wdata,
  output logic [3:0]      DMem_we,
  output logic            DMem_req,
  input  logic            DMem_ready,
  input  logic            DMem_rvalid,
  input  logic [XLEN-1:0] DMem_rdata,
  output logic            Stall,
  output logic            Misaligned,
  output logic            RegWEn,
  output logic [4:0]      RD_addr,
  output logic [XLEN-1:0] Data_D,
  output logic [XLEN-1:0] Data_D_ff1
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [1:0]      addr_lo;
  logic            is_load;
  logic            is_store;
  logic            mem_op;
  logic            aligned;
  wb_sel_t         wb_sel;
  mem_state_t      state;
  logic            stall;
  logic            req;
  logic            misaligned;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_value;
  logic            unused_inst_bits;

  assign opcode           = Inst_Execute[6:0];
  assign funct3           = Inst_Execute[14:12];
  assign RD_addr          = Inst_Execute[11:7];
  assign addr_lo          = ALU_out_reg[1:0];
  assign unused_inst_bits = ^Inst_Execute[31:15];

  assign is_load  = opcode == OPC_LOAD;
  assign is_store = opcode == OPC_STORE;
  assign mem_op   = is_load | is_store;
  assign aligned  = access_aligned(funct3[1:0], addr_lo);

  always_comb begin
    wb_sel = WB_NONE;
    case (opcode)
      OPC_LOAD:                              wb_sel = WB_LOAD;
      OPC_JAL, OPC_JALR:                     wb_sel = WB_PC4;
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: wb_sel = WB_ALU;
      default:                               wb_sel = WB_NONE;
    endcase
  end

  // Requests go out combinationally from IDLE; a load always stalls at least
  // one cycle because its data can only arrive after the request is accepted.
  always_comb begin
    req        = 1'b0;
    stall      = 1'b0;
    misaligned = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (mem_op) begin
            if (!aligned) begin
              misaligned = 1'b1;
            end else begin
              req   = 1'b1;
              stall = is_load | ~DMem_ready;
            end
          end
        end
        ST_WAIT_RESP: stall = ~DMem_rvalid;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (req && is_load && DMem_ready) state <= ST_WAIT_RESP;
        ST_WAIT_RESP: if (DMem_rvalid) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .rdata   (DMem_rdata),
    .addr_lo (addr_lo),
    .funct3  (funct3),
    .result  (load_data)
  );

  always_comb begin
    wb_value = ALU_out_reg;
    case (wb_sel)
      WB_LOAD: wb_value = load_data;
      WB_PC4:  wb_value = PC_addr_Execute + XLEN'(4);
      default: wb_value = ALU_out_reg;
    endcase
  end

  // Stores replicate the datum into every lane; the byte enables pick the lane.
  always_comb begin
    case (funct3[1:0])
      2'b00:   DMem_wdata = {4{Data_W[7:0]}};
      2'b01:   DMem_wdata = {2{Data_W[15:0]}};
      default: DMem_wdata = Data_W;
    endcase
  end

  assign DMem_addr  = {ALU_out_reg[XLEN-1:2], 2'b00};
  assign DMem_we    = is_store ? byte_mask(funct3[1:0], addr_lo) : 4'b0000;
  assign DMem_req   = req;
  assign Stall      = stall;
  assign Misaligned = misaligned;
  assign Data_D     = wb_value;
  assign RegWEn     = ~rst & (wb_sel != WB_NONE) & (RD_addr != 5'd0) & ~stall & ~misaligned;

  // Only retired values reach the second forwarding path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Data_D_ff1 <= '0;
    end else if (!stall) begin
      Data_D_ff1 <= wb_value;
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Randomized bench for mem_writeback with a behavioural reference model and
// a few hand-computed literal expectations from the stage's documented rules.
module tb_mem_writeback;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu = RESET_PC;
  logic [31:0] pc = RESET_PC;
  logic [31:0] inst = NOP;
  logic [31:0] dw = '0;
  logic        ready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;

  logic [31:0] DMem_addr, DMem_wdata, Data_D, Data_D_ff1;
  logic [3:0]  DMem_we;
  logic        DMem_req, Stall, Misaligned, RegWEn;
  logic [4:0]  RD_addr;

  mem_writeback #(.XLEN(XLEN)) dut (
    .clk             (clk),
    .rst             (rst),
    .ALU_out_reg     (alu),
    .PC_addr_Execute (pc),
    .Inst_Execute    (inst),
    .Data_W          (dw),
    .DMem_addr       (DMem_addr),
    .DMem_wdata      (DMem_wdata),
    .DMem_we         (DMem_we),
    .DMem_req        (DMem_req),
    .DMem_ready      (ready),
    .DMem_rvalid     (rvalid),
    .DMem_rdata      (rdata),
    .Stall           (Stall),
    .Misaligned      (Misaligned),
    .RegWEn          (RegWEn),
    .RD_addr         (RD_addr),
    .Data_D          (Data_D),
    .Data_D_ff1      (Data_D_ff1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit check_en = 0;

  logic        exp_req, exp_stall, exp_mis, exp_regwen;
  logic [31:0] exp_addr, exp_wdata, exp_data;
  logic [3:0]  exp_we;
  logic [4:0]  exp_rd;

  logic        m_wait = 1'b0;
  logic [31:0] m_ff1 = '0;
  bit          m_ff1_known = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {17'h0, f3, rd, op};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int lane, input logic [2:0] f3);
    longint v;
    logic [31:0] s;
    s = word >> (8 * lane);
    case (f3)
      3'b000: begin v = s % 256;   if (v >= 128)   v -= 256;   end
      3'b100: v = s % 256;
      3'b001: begin v = s % 65536; if (v >= 32768) v -= 65536; end
      3'b101: v = s % 65536;
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  // Outputs the stage must show for the current inputs and model state.
  function automatic void compute_expected();
    logic [6:0] op;
    logic [2:0] f3;
    int size, lane;
    bit is_ld, is_st, wb, al;
    op = inst[6:0];
    f3 = inst[14:12];
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    lane = int'(alu % 4);
    is_ld = op == 7'h03;
    is_st = op == 7'h23;
    wb = (op == 7'h03) || (op == 7'h6f) || (op == 7'h67) || (op == 7'h37) ||
         (op == 7'h17) || (op == 7'h33) || (op == 7'h13);
    al = (lane % size) == 0;
    exp_rd = inst[11:7];
    exp_addr = alu - 32'(lane);
    exp_wdata = (size == 1) ? 32'(dw[7:0]) * 32'h01010101 :
                (size == 2) ? 32'(dw[15:0]) * 32'h00010001 : dw;
    exp_we = is_st ? 4'(((1 << size) - 1) << lane) : 4'h0;
    exp_data = is_ld ? ref_load(rdata, lane, f3) :
               ((op == 7'h6f) || (op == 7'h67)) ? pc + 32'd4 : alu;
    exp_req = 0; exp_stall = 0; exp_mis = 0; exp_regwen = 0;
    if (rst) begin
    end else if (m_wait) begin
      exp_stall = !rvalid;
      exp_regwen = rvalid && wb && (exp_rd != 0);
    end else begin
      exp_mis = (is_ld || is_st) && !al;
      exp_req = (is_ld || is_st) && al;
      exp_stall = exp_req && (is_ld || !ready);
      exp_regwen = wb && (exp_rd != 0) && !exp_stall && !exp_mis;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 1'b0;
      m_ff1 <= '0;
      m_ff1_known <= 1;
    end else begin
      if (!m_wait && exp_req && inst[6:0] == 7'h03 && ready) m_wait <= 1'b1;
      else if (m_wait && rvalid) m_wait <= 1'b0;
      if (!exp_stall) begin
        m_ff1 <= exp_data;
        m_ff1_known <= exp_regwen;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_output("stall", 32'(Stall), 32'(exp_stall));
      check_output("req", 32'(DMem_req), 32'(exp_req));
      check_output("misaligned", 32'(Misaligned), 32'(exp_mis));
      check_output("regwen", 32'(RegWEn), 32'(exp_regwen));
      check_output("rd_addr", 32'(RD_addr), 32'(exp_rd));
      if (exp_req) begin
        check_output("dmem_addr", DMem_addr, exp_addr);
        check_output("dmem_we", 32'(DMem_we), 32'(exp_we));
        if (inst[6:0] == 7'h23) check_output("dmem_wdata", DMem_wdata, exp_wdata);
      end
      if (exp_regwen) check_output("data_d", Data_D, exp_data);
      if (m_ff1_known) check_output("data_d_ff1", Data_D_ff1, m_ff1);
    end
  end

  // One cycle: drive just after the rising edge, return just after the model check.
  task automatic apply_stimulus(input logic r, input logic [31:0] i, input logic [31:0] a,
                                input logic [31:0] p, input logic [31:0] d, input logic rdy,
                                input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst = r; inst = i; alu = a; pc = p; dw = d; ready = rdy; rvalid = rv; rdata = rd;
    #1;
    compute_expected();
    check_en = 1;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [6:0] op;
    logic [2:0] ld_f3 [5];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    r = $urandom();
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    f3 = r[14:12];
    case ($urandom_range(0, 9))
      0, 1: begin op = 7'h03; f3 = ld_f3[$urandom_range(0, 4)]; end
      2, 3: begin op = 7'h23; f3 = 3'($urandom_range(0, 2)); end
      4: op = 7'h6f;
      5: op = 7'h67;
      6: op = r[0] ? 7'h37 : 7'h17;
      7: op = 7'h33;
      8: op = 7'h13;
      default: op = r[1] ? 7'h63 : 7'h73;
    endcase
    return {r[31:15], f3, rd, op};
  endfunction

  initial begin
    logic [31:0] ri, ra, rp, rd;
    // Reset holds every control output low, even with a load presented.
    apply_stimulus(1, NOP, 32'h0, RESET_PC, 32'h0, 0, 0, 32'h0);
    check_output("rst_ff1", Data_D_ff1, 32'h0);
    check_output("rst_stall", 32'(Stall), 32'h0);
    apply_stimulus(1, mk(3'b010, 5'd5, 7'h03), 32'h100, RESET_PC, 32'h0, 1, 0, 32'h0);
    check_output("rst_req", 32'(DMem_req), 32'h0);
    check_output("rst_regwen", 32'(RegWEn), 32'h0);
    apply_stimulus(0, NOP, 32'h0, RESET_PC, 32'h0, 0, 0, 32'h0);

    // LW 0x100 with a zero-wait memory.
    apply_stimulus(0, mk(3'b010, 5'd5, 7'h03), 32'h100, 32'h10, 32'h0, 1, 0, 32'h0);
    check_output("lw_stall", 32'(Stall), 32'h1);
    check_output("lw_addr", DMem_addr, 32'h100);
    apply_stimulus(0, mk(3'b010, 5'd5, 7'h03), 32'h100, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF);
    check_output("lw_data", Data_D, 32'hDEADBEEF);
    check_output("lw_regwen", 32'(RegWEn), 32'h1);
    check_output("lw_stall_rv", 32'(Stall), 32'h0);
    apply_stimulus(0, NOP, 32'h0, 32'h14, 32'h0, 0, 0, 32'h0);
    check_output("lw_ff1", Data_D_ff1, 32'hDEADBEEF);

    // LB / LBU from the top byte lane.
    apply_stimulus(0, mk(3'b000, 5'd6, 7'h03), 32'h103, 32'h18, 32'h0, 1, 0, 32'h0);
    apply_stimulus(0, mk(3'b000, 5'd6, 7'h03), 32'h103, 32'h18, 32'h0, 0, 1, 32'h80FFFFFF);
    check_output("lb_data", Data_D, 32'hFFFFFF80);
    apply_stimulus(0, mk(3'b100, 5'd6, 7'h03), 32'h103, 32'h1c, 32'h0, 1, 0, 32'h0);
    apply_stimulus(0, mk(3'b100, 5'd6, 7'h03), 32'h103, 32'h1c, 32'h0, 0, 1, 32'h80FFFFFF);
    check_output("lbu_data", Data_D, 32'h00000080);

    // SH to the upper halfword.
    apply_stimulus(0, mk(3'b001, 5'd2, 7'h23), 32'h202, 32'h20, 32'h1234ABCD, 1, 0, 32'h0);
    check_output("sh_we", 32'(DMem_we), 32'hC);
    check_output("sh_wdata", DMem_wdata, 32'hABCDABCD);
    check_output("sh_addr", DMem_addr, 32'h200);
    check_output("sh_stall", 32'(Stall), 32'h0);

    // Misaligned LW pulses for one cycle only.
    apply_stimulus(0, mk(3'b010, 5'd8, 7'h03), 32'h101, 32'h24, 32'h0, 1, 0, 32'h0);
    check_output("mis_pulse", 32'(Misaligned), 32'h1);
    check_output("mis_req", 32'(DMem_req), 32'h0);
    check_output("mis_regwen", 32'(RegWEn), 32'h0);
    check_output("mis_stall", 32'(Stall), 32'h0);
    apply_stimulus(0, NOP, 32'h0, 32'h28, 32'h0, 1, 0, 32'h0);
    check_output("mis_clear", 32'(Misaligned), 32'h0);

    // SW held off by DMem_ready for three cycles.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, mk(3'b010, 5'd0, 7'h23), 32'h300, 32'h2c, 32'hCAFEF00D, 0, 0, 32'h0);
      check_output("sw_wait_stall", 32'(Stall), 32'h1);
      check_output("sw_wait_wdata", DMem_wdata, 32'hCAFEF00D);
      check_output("sw_wait_we", 32'(DMem_we), 32'hF);
    end
    apply_stimulus(0, mk(3'b010, 5'd0, 7'h23), 32'h300, 32'h2c, 32'hCAFEF00D, 1, 0, 32'h0);
    check_output("sw_done_stall", 32'(Stall), 32'h0);
    check_output("sw_done_req", 32'(DMem_req), 32'h1);

    // JAL link value, and rd = x0 suppresses the write.
    apply_stimulus(0, mk(3'b000, 5'd1, 7'h6f), 32'h1234, 32'h40, 32'h0, 0, 0, 32'h0);
    check_output("jal_data", Data_D, 32'h44);
    check_output("jal_regwen", 32'(RegWEn), 32'h1);
    apply_stimulus(0, mk(3'b000, 5'd0, 7'h6f), 32'h1234, 32'h40, 32'h0, 0, 0, 32'h0);
    check_output("jal_x0_regwen", 32'(RegWEn), 32'h0);

    // Reset while waiting for a load response drops the response.
    apply_stimulus(0, mk(3'b010, 5'd7, 7'h03), 32'h400, 32'h48, 32'h0, 1, 0, 32'h0);
    apply_stimulus(0, mk(3'b010, 5'd7, 7'h03), 32'h400, 32'h48, 32'h0, 0, 0, 32'h0);
    check_output("wr_still_wait", 32'(Stall), 32'h1);
    apply_stimulus(1, mk(3'b010, 5'd7, 7'h03), 32'h400, 32'h48, 32'h0, 0, 1, 32'h55AA55AA);
    check_output("wr_rst_stall", 32'(Stall), 32'h0);
    check_output("wr_rst_regwen", 32'(RegWEn), 32'h0);
    check_output("wr_rst_ff1", Data_D_ff1, 32'h0);
    apply_stimulus(0, NOP, 32'h0, 32'h4c, 32'h0, 0, 1, 32'h55AA55AA);
    check_output("wr_after_stall", 32'(Stall), 32'h0);
    check_output("wr_after_ff1", Data_D_ff1, 32'h0);
    apply_stimulus(0, mk(3'b010, 5'd7, 7'h03), 32'h400, 32'h50, 32'h0, 0, 1, 32'h55AA55AA);
    check_output("idle_ignores_rvalid", 32'(RegWEn), 32'h0);
    apply_stimulus(0, mk(3'b010, 5'd7, 7'h03), 32'h400, 32'h50, 32'h0, 1, 0, 32'h0);
    apply_stimulus(0, mk(3'b010, 5'd7, 7'h03), 32'h400, 32'h50, 32'h0, 0, 1, 32'h0BADF00D);
    check_output("reload_data", Data_D, 32'h0BADF00D);
    apply_stimulus(0, NOP, 32'h0, 32'h54, 32'h0, 0, 0, 32'h0);

    // Random traffic; instructions are held while the model says the stage stalls.
    ri = NOP; ra = '0; rp = '0; rd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!exp_stall) begin
        ri = rand_inst();
        ra = $urandom();
        rp = $urandom() & 32'hFFFFFFFC;
        rd = $urandom();
      end
      if (m_wait)
        apply_stimulus(0, ri, ra, rp, rd, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2) == 0, $urandom());
      else
        apply_stimulus(0, ri, ra, rp, rd, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) == 0, $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
